// File: rtl/traffic_pkg.sv
// Shared encodings for the signal conflict monitor: light codes, phase states,
// fault bit positions and the first_fault codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_GREEN   = 2'b01,
    LIGHT_YELLOW  = 2'b10,
    LIGHT_INVALID = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    PH_UNKNOWN = 2'd0,
    PH_RED     = 2'd1,
    PH_GREEN   = 2'd2,
    PH_YELLOW  = 2'd3
  } phase_t;

  localparam int NUM_FAULTS      = 5;
  localparam int FB_CONFLICT     = 0;
  localparam int FB_ORDER        = 1;
  localparam int FB_SHORT_YELLOW = 2;
  localparam int FB_LONG_GREEN   = 3;
  localparam int FB_INVALID      = 4;

  localparam logic [2:0] FF_NONE         = 3'd0;
  localparam logic [2:0] FF_CONFLICT     = 3'd1;
  localparam logic [2:0] FF_ORDER        = 3'd2;
  localparam logic [2:0] FF_SHORT_YELLOW = 3'd3;
  localparam logic [2:0] FF_LONG_GREEN   = 3'd4;
  localparam logic [2:0] FF_INVALID      = 3'd5;

  // Lowest set fault bit wins when several faults land in the same cycle.
  function automatic logic [2:0] first_fault_code(input logic [NUM_FAULTS-1:0] f);
    if (f[FB_CONFLICT])          first_fault_code = FF_CONFLICT;
    else if (f[FB_ORDER])        first_fault_code = FF_ORDER;
    else if (f[FB_SHORT_YELLOW]) first_fault_code = FF_SHORT_YELLOW;
    else if (f[FB_LONG_GREEN])   first_fault_code = FF_LONG_GREEN;
    else if (f[FB_INVALID])      first_fault_code = FF_INVALID;
    else                         first_fault_code = FF_NONE;
  endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// Per-direction phase FSM and dwell counter; flags order, yellow-dwell,
// green-dwell and invalid-code faults on the registered light code.
//
// state      | meaning
// PH_UNKNOWN | no valid code seen since reset; next valid code is adopted unchecked
// PH_RED     | direction showing red
// PH_GREEN   | direction showing green
// PH_YELLOW  | direction showing yellow
module light_phase_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 10,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            i_code,
  output logic [NUM_FAULTS-1:0] o_flags
);

  phase_t             r_state;
  phase_t             w_state_nxt;
  phase_t             w_code_phase;
  logic               w_valid;
  logic [CNT_W-1:0]   r_dwell;
  logic [CNT_W-1:0]   w_dwell_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PH_UNKNOWN;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell;
    o_flags      = '0;
    w_code_phase = PH_UNKNOWN;
    w_valid      = 1'b1;
    case (i_code)
      LIGHT_RED:    w_code_phase = PH_RED;
      LIGHT_GREEN:  w_code_phase = PH_GREEN;
      LIGHT_YELLOW: w_code_phase = PH_YELLOW;
      default:      w_valid      = 1'b0;
    endcase

    // An invalid code freezes both the phase and its dwell count.
    if (!w_valid) begin
      o_flags[FB_INVALID] = 1'b1;
    end else if (w_code_phase != r_state) begin
      w_state_nxt = w_code_phase;
      w_dwell_nxt = CNT_W'(1);
      if (r_state != PH_UNKNOWN) begin
        if (!((r_state == PH_RED    && w_code_phase == PH_GREEN)  ||
              (r_state == PH_GREEN  && w_code_phase == PH_YELLOW) ||
              (r_state == PH_YELLOW && w_code_phase == PH_RED)))
          o_flags[FB_ORDER] = 1'b1;
        if (r_state == PH_YELLOW && w_code_phase == PH_RED &&
            r_dwell < CNT_W'(MIN_YELLOW))
          o_flags[FB_SHORT_YELLOW] = 1'b1;
      end
    end else begin
      if (r_dwell != {CNT_W{1'b1}})
        w_dwell_nxt = r_dwell + 1'b1;
      // Fires only on the hold that takes dwell from MAX_GREEN to MAX_GREEN+1.
      if (r_state == PH_GREEN && r_dwell == CNT_W'(MAX_GREEN))
        o_flags[FB_LONG_GREEN] = 1'b1;
    end
  end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Registers the NS/EW light codes, tracks each direction and latches sticky faults.
// Optional flashing-red override request is built when FAULT_FLASH_EN is defined.
module signal_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW   = 3,
  parameter int MAX_GREEN    = 10,
  parameter int CNT_W        = 8,
  parameter int FLASH_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [1:0]            NS,
  input  logic [1:0]            EW,
  output logic [NUM_FAULTS-1:0] fault_vec,
  output logic                  fault_any,
  output logic [2:0]            first_fault,
  output logic                  fault_dir,
  output logic                  flash_red
);

  logic [1:0]            r_ns;
  logic [1:0]            r_ew;
  logic [NUM_FAULTS-1:0] w_ns_flags;
  logic [NUM_FAULTS-1:0] w_ew_flags;
  logic [NUM_FAULTS-1:0] w_det;
  logic                  w_dir;
  logic [NUM_FAULTS-1:0] r_fault_vec;
  logic [NUM_FAULTS-1:0] w_fault_nxt;
  logic [2:0]            r_first;
  logic [2:0]            w_first_nxt;
  logic                  r_dir;
  logic                  w_dir_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ns <= LIGHT_RED;
      r_ew <= LIGHT_RED;
    end else begin
      r_ns <= NS;
      r_ew <= EW;
    end
  end

  light_phase_tracker #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_GREEN  (MAX_GREEN),
    .CNT_W      (CNT_W)
  ) u_ns_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_code  (r_ns),
    .o_flags (w_ns_flags)
  );

  light_phase_tracker #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_GREEN  (MAX_GREEN),
    .CNT_W      (CNT_W)
  ) u_ew_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_code  (r_ew),
    .o_flags (w_ew_flags)
  );

  // Conflict is the only fault not tied to a direction; it reports as NS.
  always_comb begin
    w_det              = w_ns_flags | w_ew_flags;
    w_det[FB_CONFLICT] = (r_ns != LIGHT_RED) && (r_ew != LIGHT_RED);
    w_dir              = 1'b0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (w_det[i])
        w_dir = w_ew_flags[i] & ~w_ns_flags[i];
    end
  end

  // A fault seen in the clear cycle survives the clear.
  always_comb begin
    w_fault_nxt = clear ? w_det : (r_fault_vec | w_det);
    w_first_nxt = clear ? FF_NONE : r_first;
    w_dir_nxt   = clear ? 1'b0 : r_dir;
    if (w_first_nxt == FF_NONE && (|w_det)) begin
      w_first_nxt = first_fault_code(w_det);
      w_dir_nxt   = w_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_vec <= '0;
      r_first     <= FF_NONE;
      r_dir       <= 1'b0;
    end else begin
      r_fault_vec <= w_fault_nxt;
      r_first     <= w_first_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  assign fault_vec   = r_fault_vec;
  assign fault_any   = |r_fault_vec;
  assign first_fault = r_first;
  assign fault_dir   = r_dir;

`ifdef FAULT_FLASH_EN
  localparam int FLASH_CNT_W = $clog2(FLASH_PERIOD + 1);

  logic [FLASH_CNT_W-1:0] r_flash_cnt;
  logic                   r_flash;

  // Down-counter reloads each half-period; flash starts high as fault_any rises.
  always_ff @(posedge clk) begin
    if (reset || !(|w_fault_nxt)) begin
      r_flash     <= 1'b0;
      r_flash_cnt <= '0;
    end else if (!fault_any) begin
      r_flash     <= 1'b1;
      r_flash_cnt <= FLASH_CNT_W'(FLASH_PERIOD - 1);
    end else if (r_flash_cnt == '0) begin
      r_flash     <= ~r_flash;
      r_flash_cnt <= FLASH_CNT_W'(FLASH_PERIOD - 1);
    end else begin
      r_flash_cnt <= r_flash_cnt - 1'b1;
    end
  end

  assign flash_red = r_flash;
`else
  assign flash_red = 1'b0;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Self-checking bench: directed scenarios plus randomized light sequences,
// compared every cycle against a rule-level model of the monitor.
module tb_signal_conflict_monitor;

  localparam int MIN_YELLOW   = 3;
  localparam int MAX_GREEN    = 10;
  localparam int CNT_W        = 8;
  localparam int FLASH_PERIOD = 4;
  localparam int DW_MAX       = (1 << CNT_W) - 1;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] NS = 2'b00;
  logic [1:0] EW = 2'b00;
  logic [4:0] fault_vec;
  logic       fault_any;
  logic [2:0] first_fault;
  logic       fault_dir;
  logic       flash_red;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  signal_conflict_monitor #(
    .MIN_YELLOW   (MIN_YELLOW),
    .MAX_GREEN    (MAX_GREEN),
    .CNT_W        (CNT_W),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .NS          (NS),
    .EW          (EW),
    .fault_vec   (fault_vec),
    .fault_any   (fault_any),
    .first_fault (first_fault),
    .fault_dir   (fault_dir),
    .flash_red   (flash_red)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase per direction: -1 unknown, else the light code (0 R, 1 G, 2 Y),
  // so the legal successor of a phase p is simply (p+1)%3.
  int         m_ph[2];
  int         m_dw[2];
  logic [1:0] m_ns, m_ew;
  logic [4:0] m_fv;
  int         m_ff;
  bit         m_fd;
  bit         m_flash;
  int         m_age;

  task automatic model_reset();
    m_ph[0] = -1; m_ph[1] = -1;
    m_dw[0] = 0;  m_dw[1] = 0;
    m_ns = 2'b00; m_ew = 2'b00;
    m_fv = '0; m_ff = 0; m_fd = 1'b0;
    m_flash = 1'b0; m_age = 0;
  endtask

  task automatic dir_step(input int d, input logic [1:0] c, output logic [4:0] f);
    f = '0;
    if (c == X) begin
      f[4] = 1'b1;
    end else if (m_ph[d] < 0) begin
      m_ph[d] = int'(c);
      m_dw[d] = 1;
    end else if (int'(c) == m_ph[d]) begin
      if (m_ph[d] == 1 && m_dw[d] + 1 == MAX_GREEN + 1) f[3] = 1'b1;
      if (m_dw[d] < DW_MAX) m_dw[d] = m_dw[d] + 1;
    end else begin
      if (int'(c) != (m_ph[d] + 1) % 3) f[1] = 1'b1;
      if (m_ph[d] == 2 && m_dw[d] < MIN_YELLOW) f[2] = 1'b1;
      m_ph[d] = int'(c);
      m_dw[d] = 1;
    end
  endtask

  always @(posedge clk) begin
    logic [4:0] fn, fe, det;
    bit         prev_any;
    if (reset) begin
      model_reset();
    end else begin
      prev_any = (m_fv != 0);
      dir_step(0, m_ns, fn);
      dir_step(1, m_ew, fe);
      det = fn | fe;
      det[0] = (m_ns != R) && (m_ew != R);
      if (clear) begin
        m_fv = '0; m_ff = 0; m_fd = 1'b0;
      end
      m_fv = m_fv | det;
      if (m_ff == 0 && det != 0) begin
        for (int i = 4; i >= 0; i--) begin
          if (det[i]) begin
            m_ff = i + 1;
            m_fd = fe[i] && !fn[i];
          end
        end
      end
`ifdef FAULT_FLASH_EN
      if (m_fv != 0) begin
        m_age   = prev_any ? m_age + 1 : 0;
        m_flash = ((m_age / FLASH_PERIOD) % 2) == 0;
      end else begin
        m_age   = 0;
        m_flash = 1'b0;
      end
`endif
      m_ns = NS;
      m_ew = EW;
    end
  end

  always @(negedge clk) begin
    check_eq("model_fault_vec", fault_vec, m_fv);
    check_eq("model_fault_any", fault_any, m_fv != 0);
    check_eq("model_first_fault", first_fault, m_ff);
    check_eq("model_fault_dir", fault_dir, m_fd);
    check_eq("model_flash_red", flash_red, m_flash);
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [1:0] ns, input logic [1:0] ew, input int n);
    NS = ns;
    EW = ew;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    apply(R, R, 1);
    clear = 1'b0;
  endtask

  function automatic logic [1:0] next_code(input logic [1:0] c);
    int r;
    r = $urandom_range(0, 99);
    if (r < 82) return c;
    if (r < 96) return (c == Y || c == X) ? R : c + 2'd1;
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [1:0] cn, ce;
    @(negedge clk);
    reset = 1'b1;
    apply(R, R, 3);
    check_eq("reset_fault_vec", fault_vec, 5'b00000);
    check_eq("reset_first_fault", first_fault, 3'd0);
    check_eq("reset_flash_red", flash_red, 1'b0);
    reset = 1'b0;

    // full legal cycle in both directions
    apply(R, R, 2);
    apply(G, R, 5); apply(Y, R, 3); apply(R, R, 2);
    apply(R, G, 5); apply(R, Y, 3); apply(R, R, 3);
    check_eq("legal_cycle_clean", fault_vec, 5'b00000);

    // both green: conflict appears two edges after application
    apply(G, G, 1);
    check_eq("conflict_not_yet", fault_vec, 5'b00000);
    apply(G, G, 1);
    check_eq("conflict_vec", fault_vec, 5'b00001);
    check_eq("conflict_first", first_fault, 3'd1);
    apply(Y, Y, 3); apply(R, R, 3);
    pulse_clear();
    check_eq("clear_vec", fault_vec, 5'b00000);
    check_eq("clear_first", first_fault, 3'd0);
    check_eq("clear_any", fault_any, 1'b0);

    // short yellow on NS
    apply(G, R, 3); apply(Y, R, 2); apply(R, R, 2);
    check_eq("short_y_vec", fault_vec, 5'b00100);
    check_eq("short_y_first", first_fault, 3'd3);
    check_eq("short_y_dir", fault_dir, 1'b0);
    pulse_clear();

    // long green on EW: set only on the 11th green sample
    apply(R, G, 11);
    check_eq("long_g_not_yet", fault_vec, 5'b00000);
    apply(R, G, 1);
    check_eq("long_g_vec", fault_vec, 5'b01000);
    check_eq("long_g_first", first_fault, 3'd4);
    check_eq("long_g_dir", fault_dir, 1'b1);
    apply(R, Y, 3); apply(R, R, 2);
    apply(G, R, 2); apply(R, R, 2);
    check_eq("order_vec", fault_vec, 5'b01010);
    check_eq("order_first_kept", first_fault, 3'd4);
    pulse_clear();

    // invalid EW while NS goes green and EW was green
    apply(R, G, 2);
    apply(G, X, 2);
    check_eq("invalid_conflict_vec", fault_vec, 5'b10001);
    check_eq("invalid_conflict_first", first_fault, 3'd1);
    reset = 1'b1;
    apply(G, X, 1);
    check_eq("mid_reset_vec", fault_vec, 5'b00000);
    check_eq("mid_reset_first", first_fault, 3'd0);
    check_eq("mid_reset_dir", fault_dir, 1'b0);
    check_eq("mid_reset_flash", flash_red, 1'b0);
    reset = 1'b0;
    apply(R, R, 2);

    // randomized light sequences with occasional clear and reset
    cn = R; ce = R;
    for (int k = 0; k < 3000; k++) begin
      cn = next_code(cn);
      ce = ($urandom_range(0, 3) == 0) ? next_code(ce) : ((cn == R) ? next_code(ce) : ce);
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      apply(cn, ce, 1);
    end
    clear = 1'b0;
    reset = 1'b0;
    apply(R, R, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
